// File: rtl/program_loader_if.sv
// Command-stream and write-port bundle between the program loader and its surroundings.
// The loader side uses the master modport: it consumes the byte stream and drives
// the memory and register-file write ports. The system side uses the slave modport.
interface program_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    modport master (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Program loader: parses a byte command stream (MEM / REG / PC / START) and
// presets memory, the register file and the start PC while holding the machine
// in reset. START releases the machine; any protocol error parks the loader in ERR.
// Optional feature macro LOADER_CHECKSUM_EN: every MEM/REG/PC command carries a
// trailing XOR checksum byte over opcode and payload.
module program_loader #(
    parameter logic [29:0] DEFAULT_PC = 30'h00100000
) (
    input  logic              clk,
    input  logic              rst_n,
    program_loader_if.master  bus,
    output logic [29:0]       start_pc,
    output logic              machine_reset,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE, ADDR, IDX, DATA, WRITE, RUN, ERR
`ifdef LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    typedef enum logic [1:0] {K_MEM, K_REG, K_PC} kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q;
    logic [1:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [4:0]  idx_q;
    logic [29:0] pc_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic fire;
    logic last_byte;
    logic misaligned;

    assign fire       = bus.in_valid & bus.in_ready;
    assign last_byte  = (cnt_q == 2'd3);
    assign misaligned = (kind_q == K_MEM) && (addr_q[1:0] != 2'b00);

    assign bus.mem_addr  = addr_q[31:2];
    assign bus.mem_wdata = data_q;
    assign bus.rf_waddr  = idx_q;
    assign bus.rf_wdata  = data_q;
    assign start_pc      = pc_q;

    // State register; reset discards any partially received command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode driven by accepted bytes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    case (bus.in_data)
                        8'h01, 8'h03: state_d = ADDR;
                        8'h02:        state_d = IDX;
                        8'h04:        state_d = RUN;
                        default:      state_d = ERR;
                    endcase
                end
            end
            ADDR: begin
                if (fire && last_byte) begin
                    if (kind_q == K_MEM) state_d = DATA;
`ifdef LOADER_CHECKSUM_EN
                    else                 state_d = CHK;
`else
                    else                 state_d = IDLE;
`endif
                end
            end
            IDX: begin
                if (fire) state_d = DATA;
            end
            DATA: begin
                if (fire && last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = misaligned ? ERR : WRITE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (fire) begin
                    if (bus.in_data != csum_q) state_d = ERR;
                    else if (kind_q == K_PC)   state_d = IDLE;
                    else                       state_d = misaligned ? ERR : WRITE;
                end
            end
`endif
            WRITE:   state_d = IDLE;
            RUN:     state_d = RUN;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    // Output decode: handshake, one-cycle write strobes, run/error status.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.rf_we     = 1'b0;
        error         = 1'b0;
        machine_reset = 1'b1;
        case (state_q)
            IDLE, ADDR, IDX, DATA: bus.in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHK:                   bus.in_ready = 1'b1;
`endif
            WRITE: begin
                bus.mem_we = (kind_q == K_MEM);
                bus.rf_we  = (kind_q == K_REG);
            end
            RUN:     machine_reset = 1'b0;
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    // Field assembly: shift payload bytes MSB first, track command kind and start PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q <= K_MEM;
            cnt_q  <= 2'd0;
            addr_q <= 32'd0;
            data_q <= 32'd0;
            idx_q  <= 5'd0;
            pc_q   <= DEFAULT_PC;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= 8'd0;
`endif
        end else if (fire) begin
            case (state_q)
                IDLE: begin
                    case (bus.in_data)
                        8'h01:   kind_q <= K_MEM;
                        8'h02:   kind_q <= K_REG;
                        default: kind_q <= K_PC;
                    endcase
                end
                ADDR: begin
                    addr_q <= {addr_q[23:0], bus.in_data};
                    cnt_q  <= cnt_q + 2'd1;
`ifndef LOADER_CHECKSUM_EN
                    if (last_byte && kind_q == K_PC)
                        pc_q <= {addr_q[23:0], bus.in_data[7:2]};
`endif
                end
                IDX: idx_q <= bus.in_data[4:0];
                DATA: begin
                    data_q <= {data_q[23:0], bus.in_data};
                    cnt_q  <= cnt_q + 2'd1;
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (kind_q == K_PC && bus.in_data == csum_q)
                        pc_q <= addr_q[31:2];
                end
`endif
                default: ;
            endcase
`ifdef LOADER_CHECKSUM_EN
            if (state_q == IDLE) csum_q <= bus.in_data;
            else                 csum_q <= csum_q ^ bus.in_data;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader. When LOADER_CHECKSUM_EN is
// defined, commands sent through sendCmd get their XOR checksum byte appended.
module tb_program_loader;

    localparam logic [29:0] DEFAULT_PC = 30'h00100000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] start_pc;
    logic        machine_reset;
    logic        error;

    int checks   = 0;
    int failures = 0;

    program_loader_if bus ();

    program_loader #(.DEFAULT_PC(DEFAULT_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .start_pc      (start_pc),
        .machine_reset (machine_reset),
        .error         (error)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Write-port monitor, sampled on the falling edge.
    int          mem_pulses = 0;
    int          rf_pulses  = 0;
    int          ready_during_write = 0;
    logic [29:0] mem_addr_log = '0;
    logic [31:0] mem_data_log = '0;
    logic [4:0]  rf_addr_log [0:3];
    logic [31:0] rf_data_log [0:3];

    always @(negedge clk) begin
        if (bus.mem_we) begin
            mem_addr_log = bus.mem_addr;
            mem_data_log = bus.mem_wdata;
            mem_pulses++;
        end
        if (bus.rf_we) begin
            rf_addr_log[rf_pulses[1:0]] = bus.rf_waddr;
            rf_data_log[rf_pulses[1:0]] = bus.rf_wdata;
            rf_pulses++;
        end
        if ((bus.mem_we || bus.rf_we) && bus.in_ready) ready_during_write++;
    end

    logic [7:0] txq [$];

    // Present one byte and wait (bounded) for it to be accepted.
    task automatic applyStimulus(input logic [7:0] b);
        bit taken = 1'b0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && !taken; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                taken = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!taken) begin
            checks++;
            failures++;
            $display("[TB] FAIL byte_accept: byte %h still pending after 40 cycles, expected acceptance", b);
        end
    endtask

    task automatic releaseBus();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    // Send txq as one command, optionally idling gap cycles between bytes.
    task automatic sendCmd(input int gap);
        logic [7:0] x = 8'h00;
        foreach (txq[i]) begin
            x = x ^ txq[i];
            applyStimulus(txq[i]);
            if (gap > 0) begin
                releaseBus();
                repeat (gap) @(negedge clk);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(x);
        if (gap > 0) releaseBus();
`endif
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_rf_we: got %b expected 0", bus.rf_we); end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL rst_error: got %b expected 0", error); end
        checks++; if (machine_reset !== 1'b1) begin failures++; $display("[TB] FAIL rst_machine_reset: got %b expected 1", machine_reset); end
        checks++; if (start_pc !== DEFAULT_PC) begin failures++; $display("[TB] FAIL rst_start_pc: got %h expected %h", start_pc, DEFAULT_PC); end
        checks++; if (bus.mem_addr !== 30'h0) begin failures++; $display("[TB] FAIL rst_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_mem_wdata: got %h expected 0", bus.mem_wdata); end
        checks++; if (bus.rf_waddr !== 5'h0) begin failures++; $display("[TB] FAIL rst_rf_waddr: got %h expected 0", bus.rf_waddr); end
        checks++; if (bus.rf_wdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_rf_wdata: got %h expected 0", bus.rf_wdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_mem_write();
        int m0 = mem_pulses;
        int r0 = rf_pulses;
        txq = '{8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        sendCmd(0);
        releaseBus();
        settle();
        checks++; if (mem_pulses !== m0 + 1) begin failures++; $display("[TB] FAIL mem_pulse_count: got %0d expected %0d", mem_pulses - m0, 1); end
        checks++; if (mem_addr_log !== 30'h1000) begin failures++; $display("[TB] FAIL mem_addr: got %h expected %h", mem_addr_log, 30'h1000); end
        checks++; if (mem_data_log !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL mem_wdata: got %h expected DEADBEEF", mem_data_log); end
        checks++; if (ready_during_write !== 0) begin failures++; $display("[TB] FAIL write_in_ready: got %0d cycles with in_ready, expected 0", ready_during_write); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL mem_then_ready: got %b expected 1", bus.in_ready); end
        checks++; if (rf_pulses !== r0) begin failures++; $display("[TB] FAIL mem_no_rf_we: got %0d expected 0", rf_pulses - r0); end
    endtask

    task automatic test_reg_write();
        int r0 = rf_pulses;
        int r1 = r0 + 1;
        int r2 = r0 + 2;
        int m0 = mem_pulses;
        txq = '{8'h02, 8'h03, 8'h00, 8'h40, 8'h02, 8'h00};
        sendCmd(0);
        txq = '{8'h02, 8'h0F, 8'h00, 8'h40, 8'h00, 8'h08};
        sendCmd(0);
        txq = '{8'h02, 8'hE0, 8'h11, 8'h22, 8'h33, 8'h44};
        sendCmd(0);
        releaseBus();
        settle();
        checks++; if (rf_pulses !== r0 + 3) begin failures++; $display("[TB] FAIL rf_pulse_count: got %0d expected 3", rf_pulses - r0); end
        checks++; if (rf_addr_log[r0[1:0]] !== 5'd3) begin failures++; $display("[TB] FAIL rf_waddr_3: got %0d expected 3", rf_addr_log[r0[1:0]]); end
        checks++; if (rf_data_log[r0[1:0]] !== 32'h00400200) begin failures++; $display("[TB] FAIL rf_wdata_3: got %h expected 00400200", rf_data_log[r0[1:0]]); end
        checks++; if (rf_addr_log[r1[1:0]] !== 5'd15) begin failures++; $display("[TB] FAIL rf_waddr_15: got %0d expected 15", rf_addr_log[r1[1:0]]); end
        checks++; if (rf_data_log[r1[1:0]] !== 32'h00400008) begin failures++; $display("[TB] FAIL rf_wdata_15: got %h expected 00400008", rf_data_log[r1[1:0]]); end
        checks++; if (rf_addr_log[r2[1:0]] !== 5'd0) begin failures++; $display("[TB] FAIL rf_waddr_0: got %0d expected 0", rf_addr_log[r2[1:0]]); end
        checks++; if (rf_data_log[r2[1:0]] !== 32'h11223344) begin failures++; $display("[TB] FAIL rf_wdata_0: got %h expected 11223344", rf_data_log[r2[1:0]]); end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL reg0_no_error: got %b expected 0", error); end
        checks++; if (mem_pulses !== m0) begin failures++; $display("[TB] FAIL reg_no_mem_we: got %0d expected 0", mem_pulses - m0); end
    endtask

    task automatic test_pc();
        txq = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00};
        sendCmd(0);
        releaseBus();
        settle();
        checks++; if (start_pc !== 30'h400) begin failures++; $display("[TB] FAIL pc_0x1000: got %h expected %h", start_pc, 30'h400); end
        checks++; if (machine_reset !== 1'b1) begin failures++; $display("[TB] FAIL pc_hold_reset: got %b expected 1", machine_reset); end
        txq = '{8'h03, 8'h00, 8'h40, 8'h00, 8'h00};
        sendCmd(0);
        releaseBus();
        settle();
        checks++; if (start_pc !== 30'h00100000) begin failures++; $display("[TB] FAIL pc_0x400000: got %h expected %h", start_pc, 30'h00100000); end
    endtask

    task automatic test_start();
        int m0 = mem_pulses;
        int seen_ready = 0;
        int seen_run_reset = 0;
        @(negedge clk);
        checks++; if (machine_reset !== 1'b1) begin failures++; $display("[TB] FAIL pre_start_reset: got %b expected 1", machine_reset); end
        applyStimulus(8'h04);
        @(negedge clk);
        checks++; if (machine_reset !== 1'b0) begin failures++; $display("[TB] FAIL start_reset_falls: got %b expected 0", machine_reset); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL run_in_ready: got %b expected 0", bus.in_ready); end
        bus.in_data  = 8'h01;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.in_ready) seen_ready++;
            if (machine_reset) seen_run_reset++;
        end
        releaseBus();
        settle();
        checks++; if (seen_ready !== 0) begin failures++; $display("[TB] FAIL run_ignores_bytes: got %0d ready cycles expected 0", seen_ready); end
        checks++; if (seen_run_reset !== 0) begin failures++; $display("[TB] FAIL run_reset_stays_low: got %0d high cycles expected 0", seen_run_reset); end
        checks++; if (mem_pulses !== m0) begin failures++; $display("[TB] FAIL run_no_write: got %0d expected 0", mem_pulses - m0); end
    endtask

    task automatic test_bad_opcode();
        int m0 = mem_pulses;
        doReset();
        applyStimulus(8'h7F);
        releaseBus();
        settle();
        checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL badop_error: got %b expected 1", error); end
        checks++; if (machine_reset !== 1'b1) begin failures++; $display("[TB] FAIL badop_machine_reset: got %b expected 1", machine_reset); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL badop_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (mem_pulses !== m0) begin failures++; $display("[TB] FAIL badop_no_write: got %0d expected 0", mem_pulses - m0); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_error: got %b expected 0", error); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL async_reset_ready: got %b expected 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_misaligned();
        int m0 = mem_pulses;
        doReset();
        txq = '{8'h01, 8'h00, 8'h00, 8'h40, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        sendCmd(0);
        releaseBus();
        settle();
        checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL misalign_error: got %b expected 1", error); end
        checks++; if (mem_pulses !== m0) begin failures++; $display("[TB] FAIL misalign_no_write: got %0d expected 0", mem_pulses - m0); end
        checks++; if (machine_reset !== 1'b1) begin failures++; $display("[TB] FAIL misalign_machine_reset: got %b expected 1", machine_reset); end
    endtask

    task automatic test_reset_mid();
        int m0 = mem_pulses;
        doReset();
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        doReset();
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_idle: got %b expected 1", bus.in_ready); end
        applyStimulus(8'h04);
        releaseBus();
        settle();
        checks++; if (machine_reset !== 1'b0) begin failures++; $display("[TB] FAIL midreset_start: got %b expected 0", machine_reset); end
        checks++; if (mem_pulses !== m0) begin failures++; $display("[TB] FAIL midreset_no_write: got %0d expected 0", mem_pulses - m0); end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL midreset_error: got %b expected 0", error); end
    endtask

    task automatic test_stall();
        int m0 = mem_pulses;
        doReset();
        txq = '{8'h01, 8'h00, 8'h00, 8'h80, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        sendCmd(3);
        releaseBus();
        settle();
        checks++; if (mem_pulses !== m0 + 1) begin failures++; $display("[TB] FAIL stall_pulse_count: got %0d expected 1", mem_pulses - m0); end
        checks++; if (mem_addr_log !== 30'h2000) begin failures++; $display("[TB] FAIL stall_addr: got %h expected %h", mem_addr_log, 30'h2000); end
        checks++; if (mem_data_log !== 32'h12345678) begin failures++; $display("[TB] FAIL stall_data: got %h expected 12345678", mem_data_log); end
    endtask

    task automatic test_back_to_back();
        int m0 = mem_pulses;
        int r0 = rf_pulses;
        doReset();
        txq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        sendCmd(0);
        txq = '{8'h02, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h01};
        sendCmd(0);
        applyStimulus(8'h04);
        releaseBus();
        settle();
        checks++; if (mem_pulses !== m0 + 1) begin failures++; $display("[TB] FAIL b2b_mem_count: got %0d expected 1", mem_pulses - m0); end
        checks++; if (mem_addr_log !== 30'h4) begin failures++; $display("[TB] FAIL b2b_mem_addr: got %h expected 4", mem_addr_log); end
        checks++; if (mem_data_log !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL b2b_mem_data: got %h expected CAFEF00D", mem_data_log); end
        checks++; if (rf_pulses !== r0 + 1) begin failures++; $display("[TB] FAIL b2b_rf_count: got %0d expected 1", rf_pulses - r0); end
        checks++; if (rf_addr_log[r0[1:0]] !== 5'd31) begin failures++; $display("[TB] FAIL b2b_rf_waddr: got %0d expected 31", rf_addr_log[r0[1:0]]); end
        checks++; if (rf_data_log[r0[1:0]] !== 32'h1) begin failures++; $display("[TB] FAIL b2b_rf_wdata: got %h expected 1", rf_data_log[r0[1:0]]); end
        checks++; if (machine_reset !== 1'b0) begin failures++; $display("[TB] FAIL b2b_start: got %b expected 0", machine_reset); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        doReset();
        txq = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h13};
        foreach (txq[i]) applyStimulus(txq[i]);
        txq = '{8'h03, 8'h00, 8'h40, 8'h00, 8'h00, 8'h43};
        foreach (txq[i]) applyStimulus(txq[i]);
        releaseBus();
        settle();
        checks++; if (start_pc !== 30'h00100000) begin failures++; $display("[TB] FAIL csum_good_pc: got %h expected %h", start_pc, 30'h00100000); end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL csum_good_error: got %b expected 0", error); end
        doReset();
        txq = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h14};
        foreach (txq[i]) applyStimulus(txq[i]);
        releaseBus();
        settle();
        checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL csum_bad_error: got %b expected 1", error); end
        checks++; if (start_pc !== DEFAULT_PC) begin failures++; $display("[TB] FAIL csum_bad_pc: got %h expected %h", start_pc, DEFAULT_PC); end
    endtask
`endif

    initial begin
        $display("[TB] program_loader bench starting");
        test_reset();
        test_mem_write();
        test_reg_write();
        test_pc();
        test_start();
        test_bad_opcode();
        test_misaligned();
        test_reset_mid();
        test_stall();
        test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEFAULT_PC, 30'h00100000: word address presented on start_pc until the first PC command.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  8  command-stream byte.
REQ-005 in_valid  input  1  in_data holds a byte.
REQ-006 in_ready  output  1  loader accepts the byte this cycle; transfer = in_valid & in_ready.
REQ-007 mem_we, mem_addr[29:0], mem_wdata[31:0]  output  memory word-write port.
REQ-008 rf_we, rf_waddr[4:0], rf_wdata[31:0]  output  register-file preset port.
REQ-009 start_pc  output  30  word-address start PC for the machine.
REQ-010 machine_reset  output  1  active-high reset driven to the machine; held until a START command.
REQ-011 error  output  1  sticky protocol error.

Function
REQ-012 Stream = commands; opcode byte first, then payload, multi-byte fields MSB first.
REQ-013 Opcodes: 0x01 MEM (4 addr bytes, byte address; then 4 data bytes); 0x02 REG (1 index byte, low 5 bits used; then 4 data bytes); 0x03 PC (4 byte-address bytes); 0x04 START (no payload).
REQ-014 FSM states: IDLE, ADDR, IDX, DATA, WRITE, RUN, ERR; byte counter 2 bits selects the field byte.
REQ-015 IDLE: accepted opcode 0x01 or 0x03 -> ADDR; 0x02 -> IDX; 0x04 -> RUN; any other opcode -> ERR.
REQ-016 ADDR: after 4th byte, MEM -> DATA; PC -> start_pc <= addr[31:2], then IDLE.
REQ-017 IDX: one byte -> DATA.
REQ-018 DATA: after 4th byte -> WRITE.
REQ-019 WRITE: exactly one cycle; mem_we=1 (MEM) or rf_we=1 (REG) with stable addr/data; in_ready=0; then IDLE.
REQ-020 MEM address bits [1:0] nonzero -> ERR at WRITE entry; no write issued.
REQ-021 REG index 0 write issues rf_we with rf_waddr=0 (register file ignores it); no error.
REQ-022 in_ready=1 in IDLE, ADDR, IDX, DATA; 0 in WRITE, RUN, ERR.
REQ-023 RUN: machine_reset deasserts on entry cycle and stays 0; all further bytes ignored (in_ready=0) until reset.
REQ-024 ERR: error=1, machine_reset stays 1, no further writes; exit only by reset.
REQ-025 in_valid low mid-command stalls the FSM with no timeout; partial fields are held.
REQ-026 Minimum command cost: MEM 10 cycles, REG 7, PC 5, START 1 (including WRITE cycle).

Reset
REQ-027 Reset low asynchronously forces IDLE, counter 0, mem_we=0, rf_we=0, error=0, machine_reset=1, start_pc=DEFAULT_PC, address/data outputs 0.
REQ-028 Reset asserted mid-command discards the partial command; no write occurs.
REQ-029 Reset release takes effect on the next rising clk edge; the first byte accepted is treated as an opcode.

Configuration
REQ-030 LOADER_CHECKSUM_EN defined: each MEM/REG/PC command carries one trailing byte, the XOR of opcode and all payload bytes. Mismatch -> ERR with no write and no start_pc update. START carries no checksum.
REQ-031 LOADER_CHECKSUM_EN undefined: no checksum byte; a trailing byte is parsed as the next opcode.

Verification
REQ-032 Bytes 01 00 00 40 00 DE AD BE EF -> one-cycle mem_we with mem_addr=30'h1000 and mem_wdata=32'hDEADBEEF, then in_ready=1.
REQ-033 02 03 00 40 02 00 -> rf_we with rf_waddr=3 and rf_wdata=32'h00400200; then 02 0F 00 40 00 08 -> rf_waddr=15 and rf_wdata=32'h00400008.
REQ-034 03 00 40 00 00 then 04 -> start_pc=30'h00100000; machine_reset falls in the cycle after START is accepted; a following 01 byte is ignored.
REQ-035 Opcode 0x7F, or 01 00 00 40 01 followed by 4 data bytes -> error=1, no mem_we pulse, machine_reset remains 1.
REQ-036 Reset low after 01 00 00: FSM returns to IDLE, no write; then 04 -> RUN.
REQ-037 With LOADER_CHECKSUM_EN: 03 00 40 00 00 43 -> start_pc updated; same command with checksum 44 -> error=1.
